// File: rtl/axis_stim_syn.sv
// axis_stim_syn: self-contained AXI4-Stream traffic source.
// Emits NUM_FRAMES frames of FRAME_LEN beats with an incrementing payload,
// separated by GAP_CYCLES idle cycles. A run starts automatically after reset
// (AUTO_START = 1) or when start is seen while idle. All outputs are registered
// from the next-state values, so tvalid never depends combinationally on tready.

module axis_stim_syn #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4,
  parameter int FRAME_LEN  = 16,
  parameter int NUM_FRAMES = 4,
  parameter int GAP_CYCLES = 4,
  parameter int AUTO_START = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  output logic [DATA_WIDTH-1:0]     M_AXIS_tdata,
  output logic [DEST_WIDTH-1:0]     M_AXIS_tdest,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_tkeep,
  output logic                      M_AXIS_tlast,
  input  logic                      M_AXIS_tready,
  output logic                      M_AXIS_tvalid
);

  localparam int KEEP_W  = DATA_WIDTH / 8;
  localparam int BEAT_W  = (FRAME_LEN  > 1) ? $clog2(FRAME_LEN)  : 1;
  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Terminal counts; the GAP terminal is unused when there is no gap.
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(FRAME_LEN - 32'sd1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 32'sd1);
  localparam logic [GAP_W-1:0]   GAP_LAST   =
    GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 32'sd1) : 32'sd0);
  localparam bit HAS_GAP    = (GAP_CYCLES > 0);
  localparam bit AUTO_LAUNCH = (AUTO_START != 0);

  localparam logic [BEAT_W-1:0]     BEAT_ZERO  = {BEAT_W{1'b0}};
  localparam logic [BEAT_W-1:0]     BEAT_ONE   = BEAT_W'(32'd1);
  localparam logic [FRAME_W-1:0]    FRAME_ZERO = {FRAME_W{1'b0}};
  localparam logic [FRAME_W-1:0]    FRAME_ONE  = FRAME_W'(32'd1);
  localparam logic [GAP_W-1:0]      GAP_ZERO   = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0]      GAP_ONE    = GAP_W'(32'd1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ONE   = DATA_WIDTH'(32'd1);
  localparam logic [DEST_WIDTH-1:0] DEST_ZERO  = {DEST_WIDTH{1'b0}};
  localparam logic [KEEP_W-1:0]     KEEP_ALL   = {KEEP_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Current state and counters.
  state_t                  state_r;
  logic [BEAT_W-1:0]       beat_r;
  logic [FRAME_W-1:0]      frame_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [GAP_W-1:0]        gap_r;
  logic                    auto_r;

  // Next-state values.
  state_t                  state_s;
  logic [BEAT_W-1:0]       beat_s;
  logic [FRAME_W-1:0]      frame_s;
  logic [DATA_WIDTH-1:0]   data_s;
  logic [GAP_W-1:0]        gap_s;
  logic                    auto_s;
  logic                    xfer_s;

  // Output registers.
  logic                    tvalid_r;
  logic                    tlast_r;
  logic [DATA_WIDTH-1:0]   tdata_r;
  logic [DEST_WIDTH-1:0]   tdest_r;
  logic [KEEP_W-1:0]       tkeep_r;

  // Next-state logic: launch, per-beat counting, frame/gap sequencing.
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    frame_s = frame_r;
    data_s  = data_r;
    gap_s   = gap_r;
    auto_s  = auto_r;
    xfer_s  = tvalid_r & M_AXIS_tready;

    case (state_r)
      ST_IDLE: begin
        if (start || auto_r) begin
          state_s = ST_SEND;
          beat_s  = BEAT_ZERO;
          frame_s = FRAME_ZERO;
          data_s  = DATA_ZERO;
          auto_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (xfer_s) begin
          data_s = data_r + DATA_ONE;
          if (beat_r == BEAT_LAST) begin
            beat_s  = BEAT_ZERO;
            frame_s = frame_r + FRAME_ONE;
            if (frame_r == FRAME_LAST) begin
              state_s = ST_IDLE;
            end else if (HAS_GAP) begin
              state_s = ST_GAP;
              gap_s   = GAP_ZERO;
            end else begin
              // No gap configured: next frame follows back-to-back.
              state_s = ST_SEND;
            end
          end else begin
            beat_s = beat_r + BEAT_ONE;
          end
        end else begin
          // Stalled by the sink: hold everything.
          state_s = ST_SEND;
        end
      end

      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = ST_SEND;
        end else begin
          gap_s = gap_r + GAP_ONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset re-arms the auto-launch flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      beat_r  <= BEAT_ZERO;
      frame_r <= FRAME_ZERO;
      data_r  <= DATA_ZERO;
      gap_r   <= GAP_ZERO;
      auto_r  <= AUTO_LAUNCH;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      frame_r <= frame_s;
      data_r  <= data_s;
      gap_r   <= gap_s;
      auto_r  <= auto_s;
    end
  end

  // Output registers loaded from next-state values so the bus shows the beat
  // the FSM is about to present, one register stage and no comb path from tready.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      tdata_r  <= DATA_ZERO;
      tdest_r  <= DEST_ZERO;
      tkeep_r  <= KEEP_ALL;
    end else begin
      tvalid_r <= (state_s == ST_SEND);
      tlast_r  <= (state_s == ST_SEND) && (beat_s == BEAT_LAST);
      tdata_r  <= data_s;
      tdest_r  <= DEST_WIDTH'(frame_s);
      tkeep_r  <= KEEP_ALL;
    end
  end

  assign M_AXIS_tvalid = tvalid_r;
  assign M_AXIS_tlast  = tlast_r;
  assign M_AXIS_tdata  = tdata_r;
  assign M_AXIS_tdest  = tdest_r;
  assign M_AXIS_tkeep  = tkeep_r;

endmodule

// File: tb/tb_axis_stim_syn.sv
// Testbench for axis_stim_syn: scoreboard of expected beats, directed steps.
// dut  : default parameters (auto launch, 4 x 16 beats, gap 4).
// dut2 : 8-bit data, 2 x 200 beats, no gap, no auto launch (wrap test).

module tb_axis_stim_syn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start;
  logic        tready = 1'b1;
  logic [31:0] tdata;
  logic [3:0]  tdest;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;

  logic        start2;
  logic        tready2;
  logic [7:0]  tdata2;
  logic [0:0]  tdest2;
  logic [0:0]  tkeep2;
  logic        tlast2;
  logic        tvalid2;

  axis_stim_syn dut (
    .clk(clk), .rstn(rstn), .start(start),
    .M_AXIS_tdata(tdata), .M_AXIS_tdest(tdest), .M_AXIS_tkeep(tkeep),
    .M_AXIS_tlast(tlast), .M_AXIS_tready(tready), .M_AXIS_tvalid(tvalid)
  );

  axis_stim_syn #(
    .DATA_WIDTH(8), .DEST_WIDTH(1), .FRAME_LEN(200), .NUM_FRAMES(2),
    .GAP_CYCLES(0), .AUTO_START(0)
  ) dut2 (
    .clk(clk), .rstn(rstn), .start(start2),
    .M_AXIS_tdata(tdata2), .M_AXIS_tdest(tdest2), .M_AXIS_tkeep(tkeep2),
    .M_AXIS_tlast(tlast2), .M_AXIS_tready(tready2), .M_AXIS_tvalid(tvalid2)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        last;
    int          cyc;   // expected cycle offset from t0, -1 = don't care
  } beat_t;

  beat_t q[$];
  beat_t q2[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int t0_2 = 0;
  int run_beats = 0;
  int run_beats2 = 0;
  bit mon_en = 1'b0;
  bit rand_rdy = 1'b0;
  bit stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_dest;
  logic        prev_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter: 1 on the first edge with rstn sampled high.
  always @(posedge clk) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Sink ready: constant 1 or random, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor for dut: stability on stalls, scoreboard on transfers.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("tkeep", tkeep, 64'hF);
      if (stall_prev) begin
        chk("stall_valid", tvalid, 1'b1);
        chk("stall_data", tdata, prev_data);
        chk("stall_dest", tdest, prev_dest);
        chk("stall_last", tlast, prev_last);
      end
      if (tvalid === 1'b1 && tready === 1'b1) begin
        if (q.size() == 0) begin
          chk("extra_beat", tvalid, 1'b0);
        end else begin
          beat_t it;
          it = q.pop_front();
          chk("beat_data", tdata, it.data);
          chk("beat_dest", tdest, it.dest);
          chk("beat_last", tlast, it.last);
          if (it.cyc >= 0) chk("beat_cycle", 64'(cyc - t0), 64'(it.cyc));
          run_beats++;
        end
      end
      stall_prev = (tvalid === 1'b1) && (tready !== 1'b1);
      prev_data  = tdata;
      prev_dest  = tdest;
      prev_last  = tlast;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Monitor for dut2 (tready2 held high).
  always @(negedge clk) begin
    if (tvalid2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("dut2_extra_beat", tvalid2, 1'b0);
      end else begin
        beat_t it;
        it = q2.pop_front();
        chk("dut2_data", tdata2, it.data);
        chk("dut2_dest", tdest2, it.dest);
        chk("dut2_last", tlast2, it.last);
        chk("dut2_keep", tkeep2, 64'h1);
        chk("dut2_cycle", 64'(cyc - t0_2), 64'(it.cyc));
        run_beats2++;
      end
    end
  end

  // Expected run of 64 beats; base < 0 means timing is not checked.
  task automatic push_run(input int base);
    for (int n = 0; n < 64; n++) begin
      beat_t it;
      it.data = 32'(n);
      it.dest = 4'(n / 16);
      it.last = ((n % 16) == 15);
      it.cyc  = (base < 0) ? -1 : base + 1 + 20 * (n / 16) + (n % 16);
      q.push_back(it);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string tag);
    for (int i = 0; i < bound && q.size() != 0; i++) @(posedge clk);
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  initial begin
    rstn    = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    tready2 = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast",  tlast,  1'b0);
    chk("rst_tdata",  tdata,  64'd0);
    chk("rst_tdest",  tdest,  64'd0);
    chk("rst_tkeep",  tkeep,  64'hF);
    chk("rst_tvalid2", tvalid2, 1'b0);

    // Auto run, tready = 1: exact cycle positions, gaps of 4.
    t0 = 0;
    run_beats = 0;
    push_run(0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_drain(150, "auto_drain");
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("auto_idle_valid", tvalid, 1'b0);
    chk("auto_beats", 64'(run_beats), 64'd64);
    chk("noauto_dut2_valid", tvalid2, 1'b0);

    // Random backpressure, start pulse; a second pulse mid-run is ignored.
    rand_rdy = 1'b1;
    run_beats = 0;
    push_run(-1);
    pulse_start();
    for (int i = 0; i < 400 && run_beats < 10; i++) @(posedge clk);
    pulse_start();
    wait_drain(1000, "bp_drain");
    rand_rdy = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("bp_idle_valid", tvalid, 1'b0);
    chk("bp_beats", 64'(run_beats), 64'd64);

    // start held high: two runs separated by one idle cycle.
    @(posedge clk); #1;
    run_beats = 0;
    t0 = cyc;
    start = 1'b1;
    push_run(0);
    push_run(77);
    repeat (100) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(200, "held_drain");
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("held_idle_valid", tvalid, 1'b0);
    chk("held_beats", 64'(run_beats), 64'd128);

    // Reset at beat 20, then a fresh auto run from tdata = 0.
    run_beats = 0;
    push_run(0);
    pulse_start();
    for (int i = 0; i < 200 && run_beats < 20; i++) @(posedge clk);
    #1;
    rstn = 1'b0;
    mon_en = 1'b0;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", tvalid, 1'b0);
    chk("midrst_tdata",  tdata,  64'd0);
    chk("midrst_tlast",  tlast,  1'b0);
    chk("midrst_tdest",  tdest,  64'd0);
    run_beats = 0;
    t0 = 0;
    push_run(0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_drain(150, "rerun_drain");
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rerun_idle_valid", tvalid, 1'b0);
    chk("rerun_beats", 64'(run_beats), 64'd64);

    // dut2: 400 contiguous beats, 8-bit data wraps at beat 256.
    for (int n = 0; n < 400; n++) begin
      beat_t it;
      it.data = 32'(n % 256);
      it.dest = 4'((n / 200) % 2);
      it.last = ((n % 200) == 199);
      it.cyc  = n + 1;
      q2.push_back(it);
    end
    run_beats2 = 0;
    @(posedge clk); #1;
    t0_2 = cyc;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 600 && q2.size() != 0; i++) @(posedge clk);
    chk("dut2_drain", 64'(q2.size()), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("dut2_idle_valid", tvalid2, 1'b0);
    chk("dut2_beats", 64'(run_beats2), 64'd400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
